// File: rtl/xi_mem_arbiter.sv
// Round-robin arbiter sharing one external node-memory port between N_REQ requesters.
// One transaction in flight; each response (or timeout error) is routed back to its requester.
module xi_mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 160,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_rd_valid,
  input  logic [DATA_W-1:0]        mem_rd_data,
  input  logic                     mem_wr_ack,
  output logic                     busy,
  output logic [15:0]              timeout_count,
  output logic [1:0]               dbg_state
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

  // Handshake: a requester holds req_valid/we/addr/wdata until it sees its
  // one-cycle req_ready pulse; completion is a one-cycle rsp_valid pulse to the
  // same requester, with rsp_err/rsp_rdata held until the next completion.

  state_t            state, state_d;
  logic [IDXW-1:0]   gnt, gnt_d, rr_ptr, rr_d, pick;
  logic              we_q, we_d;
  logic [TW-1:0]     timer, timer_d;
  logic [N_REQ-1:0]  req_ready_d, rsp_valid_d, gnt_oh, pick_oh;
  logic              rsp_err_d, mem_rd_en_d, mem_wr_en_d, busy_d;
  logic [DATA_W-1:0] rsp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [15:0]       timeout_count_d;
  logic              done, expired;

  assign dbg_state = state;
  assign gnt_oh    = N_REQ'(1) << gnt;
  assign pick_oh   = N_REQ'(1) << pick;

  // Scan downward so the last hit is the nearest index at or above rr_ptr.
  always_comb begin
    int idx;
    pick = rr_ptr;
    idx  = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req_valid[idx]) pick = IDXW'(idx);
    end
  end

  assign done    = (state == WAIT_RD) ? mem_rd_valid : mem_wr_ack;
  assign expired = (TIMEOUT != 0) && (timer == TIMER_LAST);

  always_comb begin
    state_d         = state;
    gnt_d           = gnt;
    we_d            = we_q;
    rr_d            = rr_ptr;
    timer_d         = timer;
    req_ready_d     = '0;
    rsp_valid_d     = '0;
    rsp_err_d       = rsp_err;
    rsp_rdata_d     = rsp_rdata;
    mem_rd_en_d     = 1'b0;
    mem_wr_en_d     = 1'b0;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;
    timeout_count_d = timeout_count;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          gnt_d       = pick;
          we_d        = req_we[pick];
          mem_addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
          req_ready_d = pick_oh;
          mem_rd_en_d = ~req_we[pick];
          mem_wr_en_d = req_we[pick];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = we_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD, WAIT_WR: begin
        // A response in the expiry cycle still counts as a normal completion.
        if (done) begin
          rsp_valid_d = gnt_oh;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = (state == WAIT_RD) ? mem_rd_data : '0;
          rr_d        = (gnt == IDXW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
          state_d     = IDLE;
        end else if (expired) begin
          rsp_valid_d = gnt_oh;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rr_d        = (gnt == IDXW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
          if (timeout_count != 16'hFFFF) timeout_count_d = timeout_count + 16'd1;
          state_d     = IDLE;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      we_q          <= 1'b0;
      rr_ptr        <= '0;
      timer         <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_d;
      gnt           <= gnt_d;
      we_q          <= we_d;
      rr_ptr        <= rr_d;
      timer         <= timer_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_err       <= rsp_err_d;
      rsp_rdata     <= rsp_rdata_d;
      mem_rd_en     <= mem_rd_en_d;
      mem_wr_en     <= mem_wr_en_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      busy          <= busy_d;
      timeout_count <= timeout_count_d;
    end
  end

endmodule

// File: tb/tb_xi_mem_arbiter.sv
// Directed bench for xi_mem_arbiter: expected issues/responses are queued at stimulus
// time and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_xi_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 160;
  localparam int TO = 8;
  localparam int IW = N + 2 + AW + DW;
  localparam int RW = N + 1 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_err, mem_rd_en, mem_wr_en, mem_rd_valid, mem_wr_ack, busy;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rd_data;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     timeout_count;
  logic [1:0]      dbg_state;

  logic [IW-1:0] iss_q[$];
  logic [RW-1:0] exp_q[$];
  logic [IW-1:0] ie;
  logic [RW-1:0] re;
  int n_checks = 0;
  int n_pass   = 0;

  xi_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_ack(mem_wr_ack), .busy(busy), .timeout_count(timeout_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [IW-1:0] iss(input logic [N-1:0] oh, input logic we,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {oh, ~we, we, a, d};
  endfunction

  function automatic logic [RW-1:0] rsp(input logic [N-1:0] oh, input logic err,
                                        input logic [DW-1:0] d);
    return {oh, err, d};
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (req_ready != '0 || mem_rd_en || mem_wr_en) begin
      if (iss_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: ready=%b rd=%b wr=%b addr=%h", req_ready,
                 mem_rd_en, mem_wr_en, mem_addr);
      end else begin
        ie = iss_q.pop_front();
        check("issue", {req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, ie);
      end
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: rsp_valid=%b err=%b rdata=%h", rsp_valid, rsp_err,
                 rsp_rdata);
      end else begin
        re = exp_q.pop_front();
        check("rsp", {rsp_valid, rsp_err, rsp_rdata}, re);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_outs", {req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 0);
    check("rst_tcount", timeout_count, 0);
    rst = 1'b0;

    // single read on requester 1
    set_req(1, 1'b0, 20'h00ABC, 160'hDEAD);
    req_valid = 4'b0010;
    iss_q.push_back(iss(4'b0010, 1'b0, 20'h00ABC, 160'hDEAD));
    exp_q.push_back(rsp(4'b0010, 1'b0, 160'h1234));
    step(1);
    check("t1_ready", req_ready, 4'b0010);
    check("t1_rd_en", {mem_rd_en, mem_wr_en}, 2'b10);
    check("t1_addr", mem_addr, 20'h00ABC);
    req_valid = '0;
    step(1);
    check("t1_busy", busy, 1);
    mem_rd_valid = 1'b1; mem_rd_data = 160'h1234;
    step(1);
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    check("t1_rsp_valid", rsp_valid, 4'b0010);
    check("t1_rsp_data", {rsp_err, rsp_rdata}, {1'b0, 160'h1234});

    // reset clears held response data and rr_ptr
    rst = 1'b1;
    step(1);
    check("rst2_rdata", rsp_rdata, 0);
    check("rst2_busy", busy, 0);
    rst = 1'b0;

    // all four requesters hold reads: grants 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(20'h100 + i), DW'(160'hB00 + i));
    for (int k = 0; k < 5; k++) begin
      iss_q.push_back(iss(4'b0001 << (k % N), 1'b0, AW'(20'h100 + (k % N)),
                          DW'(160'hB00 + (k % N))));
      exp_q.push_back(rsp(4'b0001 << (k % N), 1'b0, DW'(160'hC0DE0 + k)));
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("t2_grant", req_ready, 4'b0001 << (k % N));
      step(2);
      mem_rd_valid = 1'b1; mem_rd_data = DW'(160'hC0DE0 + k);
      step(1);
      mem_rd_valid = 1'b0;
      check("t2_rsp_valid", rsp_valid, 4'b0001 << (k % N));
    end
    req_valid = '0;

    // write from requester 2, ack 5 cycles after issue
    set_req(2, 1'b1, 20'h00010, {20{8'hA5}});
    req_valid = 4'b0100;
    iss_q.push_back(iss(4'b0100, 1'b1, 20'h00010, {20{8'hA5}}));
    exp_q.push_back(rsp(4'b0100, 1'b0, '0));
    step(1);
    check("t3_ready", req_ready, 4'b0100);
    check("t3_wr_en", {mem_rd_en, mem_wr_en}, 2'b01);
    req_valid = '0;
    for (int j = 1; j <= 4; j++) begin
      step(1);
      check("t3_busy", {busy, rsp_valid}, {1'b1, 4'b0000});
    end
    step(1);
    check("t3_busy_ack", busy, 1);
    mem_wr_ack = 1'b1;
    step(1);
    mem_wr_ack = 1'b0;
    check("t3_rsp_valid", rsp_valid, 4'b0100);
    check("t3_rsp_err", rsp_err, 0);
    check("t3_idle_busy", busy, 0);

    // read valid coincides with timer expiry; rr_ptr=3 wraps to requester 0
    set_req(0, 1'b0, 20'h0ABCD, 160'h77);
    req_valid = 4'b0001;
    iss_q.push_back(iss(4'b0001, 1'b0, 20'h0ABCD, 160'h77));
    exp_q.push_back(rsp(4'b0001, 1'b0, 160'hFACE));
    step(1);
    check("t5_ready", req_ready, 4'b0001);
    req_valid = '0;
    step(7);
    check("t5_no_early", rsp_valid, 0);
    step(1);
    mem_rd_valid = 1'b1; mem_rd_data = 160'hFACE;
    step(1);
    mem_rd_valid = 1'b0;
    check("t5_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0001, 1'b0, 160'hFACE});
    check("t5_tcount", timeout_count, 0);

    // read with no response: error 9 cycles after issue
    set_req(1, 1'b0, 20'h0F00D, 160'h0);
    req_valid = 4'b0010;
    iss_q.push_back(iss(4'b0010, 1'b0, 20'h0F00D, 160'h0));
    exp_q.push_back(rsp(4'b0010, 1'b1, '0));
    step(1);
    check("t4_ready", req_ready, 4'b0010);
    req_valid = '0;
    step(8);
    check("t4_no_early", rsp_valid, 0);
    step(1);
    check("t4_rsp", {rsp_valid, rsp_err, rsp_rdata}, {4'b0010, 1'b1, 160'h0});
    check("t4_tcount", timeout_count, 1);
    mem_rd_valid = 1'b1; mem_rd_data = 160'h99;
    step(1);
    mem_rd_valid = 1'b0;
    step(2);
    check("t4_stray", {busy, rsp_valid}, 0);

    // reset during WAIT_RD aborts silently
    set_req(2, 1'b0, 20'h22222, 160'h2);
    req_valid = 4'b0100;
    iss_q.push_back(iss(4'b0100, 1'b0, 20'h22222, 160'h2));
    step(1);
    req_valid = '0;
    step(1);
    rst = 1'b1;
    step(1);
    check("t6_rst_ctrl", {busy, req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_data", {rsp_rdata, mem_wdata}, 0);
    check("t6_rst_tcount", timeout_count, 0);
    rst = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 160'h5;
    step(1);
    mem_rd_valid = 1'b0;
    step(1);
    check("t6_no_rsp", {busy, rsp_valid}, 0);
    set_req(0, 1'b0, 20'h00001, 160'h10);
    set_req(3, 1'b0, 20'h00003, 160'h30);
    req_valid = 4'b1001;
    iss_q.push_back(iss(4'b0001, 1'b0, 20'h00001, 160'h10));
    exp_q.push_back(rsp(4'b0001, 1'b0, 160'h3C));
    step(1);
    check("t6_grant0", req_ready, 4'b0001);
    req_valid = '0;
    step(2);
    mem_rd_valid = 1'b1; mem_rd_data = 160'h3C;
    step(1);
    mem_rd_valid = 1'b0;
    check("t6_rsp_valid", rsp_valid, 4'b0001);
    step(2);

    // final report
    check("iss_q_empty", iss_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
